// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - falling-letter spawn sequencer with keyboard delete arbitration
module spawn_scheduler #(
  parameter int          NUM_SLOTS    = 53,
  parameter int          SPAWN_PERIOD = 30,
  parameter int          HOLD_FRAMES  = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        pause,
  input  logic        kb_ready,
  input  logic [7:0]  kb_data,
  input  logic        wr_ready,
  output logic [7:0]  vmdata_wr,
  output logic        vmdata_wren,
  output logic [5:0]  vmdata_wraddr,
  output logic [7:0]  veldata_wr,
  output logic        vmdelete_wren,
  output logic [15:0] spawn_count,
  output logic [7:0]  full_skips
);

  localparam logic [5:0] LAST_SLOT   = 6'(NUM_SLOTS - 1);
  localparam logic [7:0] PERIOD_LAST = 8'(SPAWN_PERIOD - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_ISSUE  = 2'd2,
    S_DELETE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_lfsr;
  logic [5:0]  r_ptr;
  logic [5:0]  r_probe_cnt;
  logic        r_settle;
  logic [7:0]  r_timer;
  logic [7:0]  r_hold_cnt;
  logic        r_del_pend;
  logic        r_del_active;
  logic        r_kb_prev;
  logic [7:0]  r_letter;
  logic [7:0]  r_vel;
  logic [15:0] r_spawn_cnt;
  logic [7:0]  r_full_skips;

  logic        w_timer_inc;
  logic        w_timer_clr;
  logic        w_settle_set;
  logic        w_probe_step;
  logic        w_probe_full;
  logic        w_latch;
  logic        w_hold_inc;
  logic        w_issue_done;
  logic        w_del_arm;
  logic        w_del_done;
  logic        w_fb;
  logic [4:0]  w_letter_idx;
  logic [7:0]  w_letter;
  logic [5:0]  w_ptr_inc;
  logic        w_kb_edge;
  logic        w_kb_is_letter;

  // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Scale the low LFSR byte onto 0..25 so the letter is always A..Z
  assign w_letter_idx = 5'(({5'd0, r_lfsr[7:0]} * 13'd26) >> 8);
  assign w_letter     = 8'h41 + {3'd0, w_letter_idx};

  assign w_ptr_inc      = (r_ptr == LAST_SLOT) ? 6'd0 : r_ptr + 6'd1;
  assign w_kb_edge      = kb_ready & ~r_kb_prev;
  assign w_kb_is_letter = (kb_data >= 8'h41) && (kb_data <= 8'h5A);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes for the datapath
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_inc  = 1'b0;
    w_timer_clr  = 1'b0;
    w_settle_set = 1'b0;
    w_probe_step = 1'b0;
    w_probe_full = 1'b0;
    w_latch      = 1'b0;
    w_hold_inc   = 1'b0;
    w_issue_done = 1'b0;
    w_del_arm    = 1'b0;
    w_del_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_del_pend) begin
          w_state_nxt = S_DELETE;
        end else if (frame_tick && pause) begin
          if (r_timer == PERIOD_LAST) begin
            w_timer_clr = 1'b1;
            w_state_nxt = S_PROBE;
          end else begin
            w_timer_inc = 1'b1;
          end
        end
      end
      S_PROBE: begin
        if (!r_settle) begin
          // A delete is only taken between probes, never mid-sample
          if (r_del_pend) begin
            w_state_nxt = S_DELETE;
          end else begin
            w_settle_set = 1'b1;
          end
        end else if (wr_ready) begin
          w_latch     = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_probe_step = 1'b1;
          if (r_probe_cnt == LAST_SLOT) begin
            w_probe_full = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        if (frame_tick) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_issue_done = 1'b1;
            w_state_nxt  = r_del_pend ? S_DELETE : S_IDLE;
          end else begin
            w_hold_inc = 1'b1;
          end
        end
      end
      S_DELETE: begin
        if (frame_tick) begin
          if (r_del_active) begin
            w_del_done  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_del_arm = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Free-running LFSR, advances every clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  // Keyboard edge capture into the single pending-delete flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kb_prev  <= 1'b0;
      r_del_pend <= 1'b0;
    end else begin
      r_kb_prev <= kb_ready;
      if (w_del_done) begin
        r_del_pend <= 1'b0;
      end else if (w_kb_edge && w_kb_is_letter) begin
        r_del_pend <= 1'b1;
      end
    end
  end

  // Spawn timer and probe walk over the slot ring
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer     <= 8'd0;
      r_ptr       <= 6'd0;
      r_probe_cnt <= 6'd0;
      r_settle    <= 1'b0;
    end else begin
      if (w_timer_clr) begin
        r_timer <= 8'd0;
      end else if (w_timer_inc) begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_settle_set) begin
        r_settle <= 1'b1;
      end
      // NUM_SLOTS steps bring the pointer back to where the sweep began
      if (w_probe_step || w_issue_done) begin
        r_ptr <= w_ptr_inc;
      end
      if (w_probe_step) begin
        r_settle    <= 1'b0;
        r_probe_cnt <= r_probe_cnt + 6'd1;
      end
      if (w_state_nxt != S_PROBE) begin
        r_settle    <= 1'b0;
        r_probe_cnt <= 6'd0;
      end
    end
  end

  // Letter/velocity latch, hold-frame count, delete window and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_letter     <= 8'd0;
      r_vel        <= 8'd0;
      r_hold_cnt   <= 8'd0;
      r_del_active <= 1'b0;
      r_spawn_cnt  <= 16'd0;
      r_full_skips <= 8'd0;
    end else begin
      if (w_latch) begin
        r_letter   <= w_letter;
        r_vel      <= r_lfsr[15:8];
        r_hold_cnt <= 8'd0;
      end
      if (w_hold_inc) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
      if (w_issue_done) begin
        r_hold_cnt  <= 8'd0;
        r_spawn_cnt <= r_spawn_cnt + 16'd1;
      end
      if (w_probe_full && (r_full_skips != 8'hFF)) begin
        r_full_skips <= r_full_skips + 8'd1;
      end
      if (w_del_arm) begin
        r_del_active <= 1'b1;
      end else if (w_del_done) begin
        r_del_active <= 1'b0;
      end
    end
  end

  // Enables decode straight from state so a reset drops them immediately
  always_comb begin
    vmdata_wren   = (r_state == S_ISSUE);
    vmdelete_wren = (r_state == S_DELETE) && r_del_active;
  end

  assign vmdata_wr     = r_letter;
  assign veldata_wr    = r_vel;
  assign vmdata_wraddr = r_ptr;
  assign spawn_count   = r_spawn_cnt;
  assign full_skips    = r_full_skips;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb/tb_spawn_scheduler.sv - self-checking bench for spawn_scheduler
module tb_spawn_scheduler;

  localparam int NSLOT = 53;
  localparam int HOLD  = 8;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        pause;
  logic        kb_ready;
  logic [7:0]  kb_data;
  logic        wr_ready;
  logic [7:0]  vmdata_wr;
  logic        vmdata_wren;
  logic [5:0]  vmdata_wraddr;
  logic [7:0]  veldata_wr;
  logic        vmdelete_wren;
  logic [15:0] spawn_count;
  logic [7:0]  full_skips;

  int errors = 0;
  int checks = 0;

  bit occ [0:63];

  spawn_scheduler #(
    .NUM_SLOTS   (NSLOT),
    .SPAWN_PERIOD(2),
    .HOLD_FRAMES (HOLD),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .pause        (pause),
    .kb_ready     (kb_ready),
    .kb_data      (kb_data),
    .wr_ready     (wr_ready),
    .vmdata_wr    (vmdata_wr),
    .vmdata_wren  (vmdata_wren),
    .vmdata_wraddr(vmdata_wraddr),
    .veldata_wr   (veldata_wr),
    .vmdelete_wren(vmdelete_wren),
    .spawn_count  (spawn_count),
    .full_skips   (full_skips)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Display model: a slot reports empty unless the bench marked it occupied
  always_comb wr_ready = ~occ[vmdata_wraddr];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [7:0] letter_of(input logic [7:0] b);
    int idx;
    idx = (int'(b) * 26) / 256;
    return 8'(65 + idx);
  endfunction

  function automatic int find_free(input int p);
    for (int k = 0; k < NSLOT; k++) begin
      if (!occ[(p + k) % NSLOT]) return (p + k) % NSLOT;
    end
    return -1;
  endfunction

  // Reference LFSR: one step per clock from the seed
  logic [15:0] lm;
  logic [15:0] lm_last;
  always @(posedge clk or negedge reset) begin
    if (!reset) lm <= 16'hACE1;
    else        lm <= lfsr_step(lm);
  end

  // Transaction-level model state
  int ptr_m, cnt_m, exp_slot, n_ticks, d_ticks, del_seen, rises;
  bit pend_m, p_wren, p_del, p_tick, p_kb;
  logic [7:0] lat_letter, lat_vel;
  logic [5:0] lat_addr;

  initial begin
    ptr_m = 0; cnt_m = 0; del_seen = 0; rises = 0; pend_m = 0;
    p_wren = 0; p_del = 0; p_tick = 0; p_kb = 0; n_ticks = 0; d_ticks = 0;
  end

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    if (!reset) begin
      ptr_m = 0; cnt_m = 0; pend_m = 0;
      p_wren = 0; p_del = 0; p_tick = 0; p_kb = 0;
    end else begin
      check("wren_del_exclusive", int'(vmdata_wren & vmdelete_wren), 0);
      if (kb_ready && !p_kb && kb_data >= 8'h41 && kb_data <= 8'h5A && !pend_m) pend_m = 1;
      if (vmdata_wren && !p_wren) begin
        rises++;
        exp_slot = find_free(ptr_m);
        check("spawn_slot", int'(vmdata_wraddr), exp_slot);
        check("spawn_letter", int'(vmdata_wr), int'(letter_of(lm_last[7:0])));
        check("spawn_velocity", int'(veldata_wr), int'(lm_last[15:8]));
        lat_addr = vmdata_wraddr; lat_letter = vmdata_wr; lat_vel = veldata_wr;
        n_ticks = 0;
      end else if (vmdata_wren) begin
        check("issue_hold_stable", int'({vmdata_wraddr, vmdata_wr, veldata_wr}),
              int'({lat_addr, lat_letter, lat_vel}));
      end
      if (vmdata_wren && frame_tick) n_ticks++;
      if (!vmdata_wren && p_wren) begin
        check("issue_tick_count", n_ticks, HOLD);
        check("issue_end_on_tick", int'(p_tick), 1);
        check("spawn_count_inc", int'(spawn_count), cnt_m + 1);
        cnt_m++;
        ptr_m = (int'(lat_addr) + 1) % NSLOT;
      end
      if (vmdelete_wren && !p_del) begin
        check("del_had_pending", int'(pend_m), 1);
        check("del_start_after_tick", int'(p_tick), 1);
        d_ticks = 0;
      end
      if (vmdelete_wren && frame_tick) d_ticks++;
      if (!vmdelete_wren && p_del) begin
        check("del_tick_count", d_ticks, 1);
        check("del_end_on_tick", int'(p_tick), 1);
        pend_m = 0;
        del_seen++;
      end
      p_wren = vmdata_wren; p_del = vmdelete_wren; p_tick = frame_tick; p_kb = kb_ready;
    end
    lm_last = lm;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge clk); #2;
    frame_tick = 1'b0;
  endtask

  task automatic tick_gap(input int gap);
    do_tick();
    wait_cyc(gap);
  endtask

  // Cycles with wren low after the period-completing tick: settle+sample per probe
  task automatic expect_spawn(input string nm, input int exp_lat);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      if (vmdata_wren) seen = 1;
      else n++;
    end
    check(nm, seen ? n : -1, exp_lat);
    @(posedge clk); #2;
  endtask

  task automatic spawn(input string nm, input int exp_lat);
    tick_gap(5);
    do_tick();
    expect_spawn(nm, exp_lat);
  endtask

  task automatic hold_frames(input int n);
    repeat (n) tick_gap(4);
  endtask

  task automatic do_reset(input bit chk);
    reset = 1'b0;
    #1;
    if (chk) begin
      check("rst_vmdata_wr", int'(vmdata_wr), 0);
      check("rst_wren", int'(vmdata_wren), 0);
      check("rst_wraddr", int'(vmdata_wraddr), 0);
      check("rst_veldata", int'(veldata_wr), 0);
      check("rst_delete", int'(vmdelete_wren), 0);
      check("rst_spawn_count", int'(spawn_count), 0);
      check("rst_full_skips", int'(full_skips), 0);
    end
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int snap;

  initial begin
    reset = 1'b1; frame_tick = 1'b0; pause = 1'b1; kb_ready = 1'b0; kb_data = 8'h00;
    for (int i = 0; i < 64; i++) occ[i] = 1'b0;
    #3;

    // Reference-function anchors
    check("lfsr_step_ace1", int'(lfsr_step(16'hACE1)), 'h5670);
    check("letter_e1", int'(letter_of(8'hE1)), 'h57);
    check("letter_ff", int'(letter_of(8'hFF)), 'h5A);
    check("letter_00", int'(letter_of(8'h00)), 'h41);

    do_reset(1'b1);

    // Free ring: two ticks then slot 0, then slot 1
    spawn("t1_latency", 2);
    check("t1_wraddr", int'(vmdata_wraddr), 0);
    hold_frames(HOLD);
    check("t1_count1", int'(spawn_count), 1);
    spawn("t1b_latency", 2);
    check("t1b_wraddr", int'(vmdata_wraddr), 1);
    hold_frames(HOLD);
    check("t1b_count2", int'(spawn_count), 2);

    // Slots 0..4 occupied: five failed probes, write lands on 5
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) occ[i] = 1'b1;
    spawn("t2_latency", 12);
    check("t2_wraddr", int'(vmdata_wraddr), 5);
    hold_frames(HOLD);
    check("t2_count", int'(spawn_count), 1);
    for (int i = 0; i < 64; i++) occ[i] = 1'b0;

    // Every slot occupied: abandon, count, saturate
    do_reset(1'b0);
    for (int i = 0; i < NSLOT; i++) occ[i] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      do_tick();
      wait_cyc(2);
      do_tick();
      wait_cyc(115);
      if (i == 0) check("t3_skip1", int'(full_skips), 1);
      if (i == 1) check("t3_skip2", int'(full_skips), 2);
    end
    check("t3_skip_sat", int'(full_skips), 255);
    check("t3_no_spawn", int'(spawn_count), 0);
    check("t3_ptr_kept", int'(vmdata_wraddr), 0);
    for (int i = 0; i < 64; i++) occ[i] = 1'b0;

    // Delete requested mid-ISSUE waits, then lasts one frame
    spawn("t4_latency", 2);
    check("t4_wraddr", int'(vmdata_wraddr), 0);
    hold_frames(3);
    kb_data = 8'h51; kb_ready = 1'b1;
    wait_cyc(3);
    check("t4_del_blocked", int'(vmdelete_wren), 0);
    kb_ready = 1'b0;
    hold_frames(HOLD - 3);
    check("t4_count", int'(spawn_count), 1);
    check("t4_del_waits_tick", int'(vmdelete_wren), 0);
    tick_gap(5);
    check("t4_del_active", int'(vmdelete_wren), 1);
    check("t4_wren_off", int'(vmdata_wren), 0);
    tick_gap(5);
    check("t4_del_done", int'(vmdelete_wren), 0);
    check("t4_del_seen", del_seen, 1);

    // Non-letter keystroke is ignored
    pause = 1'b0;
    kb_data = 8'h31; kb_ready = 1'b1;
    wait_cyc(3);
    kb_ready = 1'b0;
    repeat (4) tick_gap(3);
    check("t4_digit_no_delete", del_seen, 1);

    // Paused: timer frozen, nothing spawns
    snap = rises;
    repeat (100) tick_gap(2);
    check("t5_paused_count", int'(spawn_count), 1);
    check("t5_paused_no_wren", rises, snap);
    pause = 1'b1;
    tick_gap(10);
    check("t5_one_tick_no_spawn", rises, snap);
    do_tick();
    expect_spawn("t5_latency", 2);
    check("t5_wraddr", int'(vmdata_wraddr), 1);
    hold_frames(HOLD);
    check("t5_count", int'(spawn_count), 2);

    // Reset during ISSUE
    do_reset(1'b0);
    spawn("t6_latency", 2);
    hold_frames(3);
    reset = 1'b0;
    #1;
    check("t6_wren_async", int'(vmdata_wren), 0);
    check("t6_count", int'(spawn_count), 0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    spawn("t6b_latency", 2);
    check("t6b_wraddr", int'(vmdata_wraddr), 0);
    hold_frames(HOLD);
    check("t6b_count", int'(spawn_count), 1);

    wait_cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
